// File: rtl/dm_bus_arbiter.sv
// Two-master round-robin bus arbiter with a single outstanding memory access.
// Each access finishes on mem_ready or is aborted after TIMEOUT busy cycles.
module dm_bus_arbiter #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        req0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   input  logic [3:0]  byteen0,
   output logic        gnt0,
   output logic        done0,
   output logic        err0,
   output logic [31:0] rdata0,

   input  logic        req1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   input  logic [3:0]  byteen1,
   output logic        gnt1,
   output logic        done1,
   output logic        err1,
   output logic [31:0] rdata1,

   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_byteen,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY0,
      BUSY1,
      DONE
   } state_t;

   localparam logic [3:0] C_WAIT_LAST = 4'(TIMEOUT - 1);

   state_t      r_state;
   logic        r_last;
   logic [3:0]  r_wait;

   logic        r_gnt0;
   logic        r_gnt1;
   logic        r_done0;
   logic        r_done1;
   logic        r_err0;
   logic        r_err1;
   logic [31:0] r_rdata0;
   logic [31:0] r_rdata1;

   logic        r_mem_valid;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [3:0]  r_mem_byteen;

   logic        w_pick0;
   logic        w_pick1;
   logic        w_owner1;
   logic        w_timeout;
   logic        w_finish;

   // r_last names the requester served most recently; the other one wins a tie.
   assign w_pick0   = req0 & (~req1 | r_last);
   assign w_pick1   = req1 & ~w_pick0;
   assign w_owner1  = (r_state == BUSY1);
   assign w_timeout = (r_wait == C_WAIT_LAST);
   assign w_finish  = mem_ready | w_timeout;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_last       <= 1'b1;
         r_wait       <= '0;
         r_gnt0       <= 1'b0;
         r_gnt1       <= 1'b0;
         r_done0      <= 1'b0;
         r_done1      <= 1'b0;
         r_err0       <= 1'b0;
         r_err1       <= 1'b0;
         r_rdata0     <= '0;
         r_rdata1     <= '0;
         r_mem_valid  <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_mem_byteen <= '0;
      end else begin
         r_gnt0  <= 1'b0;
         r_gnt1  <= 1'b0;
         r_done0 <= 1'b0;
         r_done1 <= 1'b0;

         case (r_state)
            IDLE: begin
               if (w_pick0) begin
                  r_state      <= BUSY0;
                  r_gnt0       <= 1'b1;
                  r_last       <= 1'b0;
                  r_wait       <= '0;
                  r_mem_valid  <= 1'b1;
                  r_mem_addr   <= addr0;
                  r_mem_wdata  <= wdata0;
                  r_mem_byteen <= byteen0;
               end else if (w_pick1) begin
                  r_state      <= BUSY1;
                  r_gnt1       <= 1'b1;
                  r_last       <= 1'b1;
                  r_wait       <= '0;
                  r_mem_valid  <= 1'b1;
                  r_mem_addr   <= addr1;
                  r_mem_wdata  <= wdata1;
                  r_mem_byteen <= byteen1;
               end
            end

            BUSY0, BUSY1: begin
               // mem_ready takes priority over a coincident timeout.
               if (w_finish) begin
                  r_state     <= DONE;
                  r_mem_valid <= 1'b0;
                  if (w_owner1) begin
                     r_done1  <= 1'b1;
                     r_err1   <= ~mem_ready;
                     r_rdata1 <= mem_ready ? mem_rdata : '0;
                  end else begin
                     r_done0  <= 1'b1;
                     r_err0   <= ~mem_ready;
                     r_rdata0 <= mem_ready ? mem_rdata : '0;
                  end
               end else begin
                  r_wait <= r_wait + 4'd1;
               end
            end

            DONE: begin
               r_state <= IDLE;
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign gnt0       = r_gnt0;
   assign gnt1       = r_gnt1;
   assign done0      = r_done0;
   assign done1      = r_done1;
   assign err0       = r_err0;
   assign err1       = r_err1;
   assign rdata0     = r_rdata0;
   assign rdata1     = r_rdata1;
   assign mem_valid  = r_mem_valid;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign mem_byteen = r_mem_byteen;

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Bench for dm_bus_arbiter: directed scenarios then randomized traffic, all
// checked cycle by cycle against a transaction-level reference model.
module tb_dm_bus_arbiter;

   localparam int unsigned TMO = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic [3:0]  byteen0, byteen1;
   logic        gnt0, gnt1, done0, done1, err0, err1;
   logic [31:0] rdata0, rdata1;
   logic        mem_valid;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_byteen;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   dm_bus_arbiter #(.TIMEOUT(TMO)) u_dut (
      .clk(clk), .reset(reset),
      .req0(req0), .addr0(addr0), .wdata0(wdata0), .byteen0(byteen0),
      .gnt0(gnt0), .done0(done0), .err0(err0), .rdata0(rdata0),
      .req1(req1), .addr1(addr1), .wdata1(wdata1), .byteen1(byteen1),
      .gnt1(gnt1), .done1(done1), .err1(err1), .rdata1(rdata1),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_byteen(mem_byteen), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   // Reference model: who owns the bus, how many busy cycles it has had,
   // whether we are in the one-cycle cool-down after a completion.
   int          m_owner;
   int          m_age;
   bit          m_cool;
   int          m_last;
   logic [1:0]  e_gnt, e_done, e_err;
   logic [31:0] e_rdata [2];
   logic        e_valid;
   logic [31:0] e_addr, e_wdata;
   logic [3:0]  e_be;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_age = 0; m_cool = 0; m_last = 1;
      e_gnt = '0; e_done = '0; e_err = '0;
      e_rdata[0] = '0; e_rdata[1] = '0;
      e_valid = 0; e_addr = '0; e_wdata = '0; e_be = '0;
   endtask

   task automatic model_finish(input int n, input bit is_err, input logic [31:0] d);
      e_done[n] = 1'b1;
      e_err[n] = is_err;
      e_rdata[n] = d;
      e_valid = 0;
      m_owner = -1;
      m_cool = 1;
   endtask

   task automatic model_step();
      int n;
      if (!reset) begin
         model_reset();
         return;
      end
      e_gnt = '0;
      e_done = '0;
      if (m_cool) begin
         m_cool = 0;
      end else if (m_owner >= 0) begin
         if (mem_ready) model_finish(m_owner, 0, mem_rdata);
         else if (m_age == int'(TMO)) model_finish(m_owner, 1, '0);
         else m_age++;
      end else if (req0 || req1) begin
         n = (req0 && req1) ? 1 - m_last : (req0 ? 0 : 1);
         m_owner = n; m_age = 1; m_last = n;
         e_gnt[n] = 1'b1;
         e_valid = 1;
         e_addr  = (n == 0) ? addr0 : addr1;
         e_wdata = (n == 0) ? wdata0 : wdata1;
         e_be    = (n == 0) ? byteen0 : byteen1;
      end
   endtask

   task automatic compare_all();
      chk_eq("gnt0", 32'(gnt0), 32'(e_gnt[0]));
      chk_eq("gnt1", 32'(gnt1), 32'(e_gnt[1]));
      chk_eq("done0", 32'(done0), 32'(e_done[0]));
      chk_eq("done1", 32'(done1), 32'(e_done[1]));
      chk_eq("err0", 32'(err0), 32'(e_err[0]));
      chk_eq("err1", 32'(err1), 32'(e_err[1]));
      chk_eq("rdata0", rdata0, e_rdata[0]);
      chk_eq("rdata1", rdata1, e_rdata[1]);
      chk_eq("mem_valid", 32'(mem_valid), 32'(e_valid));
      chk_eq("mem_addr", mem_addr, e_addr);
      chk_eq("mem_wdata", mem_wdata, e_wdata);
      chk_eq("mem_byteen", 32'(mem_byteen), 32'(e_be));
   endtask

   // Inputs are changed at the falling edge; the model sees the same values
   // the DUT samples at the rising edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc++;
      compare_all();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      #1 compare_all();
      tick();
      reset = 1'b1;
   endtask

   task automatic drain();
      req0 = 0; req1 = 0; mem_ready = 1;
      repeat (4) tick();
      mem_ready = 0;
   endtask

   initial begin
      #2_000_000;
      n_errors++;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int g;
      int q[$];
      int pct;
      int pcts[4] = '{0, 5, 30, 80};

      reset = 0; req0 = 0; req1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      byteen0 = '0; byteen1 = '0; mem_ready = 0; mem_rdata = '0;
      model_reset();
      #1 compare_all();
      tick();
      tick();
      reset = 1'b1;

      // single read
      req0 = 1; addr0 = 32'h0000_1000; byteen0 = 4'h0; wdata0 = $urandom;
      tick();
      chk_eq("rd_gnt0", 32'(gnt0), 32'd1);
      chk_eq("rd_addr", mem_addr, 32'h0000_1000);
      addr0 = 32'hFFFF_0000;
      tick();
      chk_eq("rd_no_early_done", 32'(done0), 32'd0);
      mem_ready = 1; mem_rdata = 32'hDEADBEEF;
      tick();
      chk_eq("rd_done0", 32'(done0), 32'd1);
      chk_eq("rd_rdata0", rdata0, 32'hDEADBEEF);
      chk_eq("rd_err0", 32'(err0), 32'd0);
      req0 = 0; mem_ready = 0; mem_rdata = 32'h5555_AAAA;
      tick();
      tick();

      // contention after reset: round-robin starting with requester 0
      do_reset();
      req0 = 1; req1 = 1; addr0 = 32'hA0; addr1 = 32'hB0; mem_ready = 1;
      repeat (16) begin
         tick();
         if (gnt0) q.push_back(0);
         if (gnt1) q.push_back(1);
      end
      chk_eq("rr_first", 32'(q.size() > 0 ? q[0] : 9), 32'd0);
      chk_eq("rr_second", 32'(q.size() > 1 ? q[1] : 9), 32'd1);
      chk_eq("rr_third", 32'(q.size() > 2 ? q[2] : 9), 32'd0);
      drain();

      // write from requester 1, wdata held until mem_ready
      req1 = 1; addr1 = 32'h7F00; wdata1 = 32'h12345678; byteen1 = 4'hF;
      tick();
      chk_eq("wr_gnt1", 32'(gnt1), 32'd1);
      req1 = 0; wdata1 = 32'hCAFE_0000; byteen1 = 4'h1;
      repeat (3) begin
         tick();
         chk_eq("wr_wdata_hold", mem_wdata, 32'h12345678);
         chk_eq("wr_be_hold", 32'(mem_byteen), 32'hF);
      end
      mem_ready = 1;
      tick();
      chk_eq("wr_done1", 32'(done1), 32'd1);
      mem_ready = 0;
      tick();

      // timeout after TMO busy cycles
      req0 = 1; addr0 = 32'h2000;
      tick();
      g = cyc;
      req0 = 0;
      while (!done0 && (cyc - g) < 40) tick();
      chk_eq("to_latency", 32'(cyc - g), 32'(TMO));
      chk_eq("to_err0", 32'(err0), 32'd1);
      chk_eq("to_rdata0", rdata0, 32'd0);
      tick();
      chk_eq("to_valid_low", 32'(mem_valid), 32'd0);
      tick();

      // mem_ready on the last allowed busy cycle completes normally
      req0 = 1; addr0 = 32'h3000;
      tick();
      req0 = 0;
      repeat (TMO - 1) tick();
      mem_ready = 1; mem_rdata = 32'h0BADF00D;
      tick();
      chk_eq("edge_done0", 32'(done0), 32'd1);
      chk_eq("edge_err0", 32'(err0), 32'd0);
      chk_eq("edge_rdata0", rdata0, 32'h0BADF00D);
      mem_ready = 0;
      tick();
      tick();

      // reset in the middle of a requester-1 access
      req1 = 1; addr1 = 32'h4000;
      tick();
      req0 = 1;
      tick();
      #2 reset = 0;
      model_reset();
      #1 chk_eq("rst_async_valid", 32'(mem_valid), 32'd0);
      compare_all();
      tick();
      chk_eq("rst_no_done1", 32'(done1), 32'd0);
      reset = 1;
      tick();
      chk_eq("rst_gnt0_first", 32'(gnt0), 32'd1);
      chk_eq("rst_gnt1_not", 32'(gnt1), 32'd0);
      drain();

      // randomized traffic with varying memory responsiveness
      for (int b = 0; b < 16; b++) begin
         pct = pcts[$urandom_range(0, 3)];
         repeat (200) begin
            req0 = ($urandom_range(0, 9) < 7);
            req1 = ($urandom_range(0, 9) < 7);
            addr0 = $urandom; addr1 = $urandom;
            wdata0 = $urandom; wdata1 = $urandom;
            byteen0 = 4'($urandom_range(0, 15));
            byteen1 = 4'($urandom_range(0, 15));
            mem_ready = ($urandom_range(0, 99) < pct);
            mem_rdata = $urandom;
            reset = ($urandom_range(0, 399) != 0);
            if (!reset) begin
               model_reset();
               #1 compare_all();
            end
            tick();
            chk_eq("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
         end
      end
      reset = 1;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
